// File: rtl/memory_responder_pkg.sv
// Shared types and constants for the en/we/ack memory responder.
package memory_responder_pkg;

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Wait = 2'd1,
    Ack  = 2'd2
  } memory_responder_fsm_t;

  localparam int CntWidth = 4;

endpackage

// File: rtl/memory_responder_byte_enable_ram.sv
// Word array with per-byte-lane synchronous write and combinational read.
module byte_enable_ram #(
  parameter int Width     = 32,
  parameter int AddrWidth = 10
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [Width/8-1:0]   sel,
  input  logic [AddrWidth-1:0] idx,
  input  logic [Width-1:0]     wr_dat,
  output logic [Width-1:0]     rd_dat
);

  logic [Width-1:0] mem [2**AddrWidth];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < Width/8; i++) begin
        if (sel[i]) mem[idx][i*8 +: 8] <= wr_dat[i*8 +: 8];
      end
    end
  end

  assign rd_dat = mem[idx];

endmodule

// File: rtl/memory_responder.sv
// Responder end of the en/we/ack handshake: one request at a time, fixed
// wait-state latency, byte-selectable write or word read, one-cycle ack.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int Width     = 32,
  parameter int AddrWidth = 10,
  parameter int Latency   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 we,
  input  logic [Width/8-1:0]   sel,
  input  logic [Width-1:0]     addr,
  input  logic [Width-1:0]     wr_dat,
  output logic [Width-1:0]     rd_dat,
  output logic                 ack,
  output logic                 busy
);

  localparam int ByteOffW = $clog2(Width/8);

  memory_responder_fsm_t state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [Width/8-1:0]    sel_q, sel_d;
  logic [AddrWidth-1:0]  idx_q, idx_d;
  logic [Width-1:0]      wdat_q, wdat_d;
  logic [Width-1:0]      rd_dat_q, rd_dat_d;

  logic [AddrWidth-1:0]  in_idx;
  logic                  access;
  logic                  acc_we;
  logic [Width/8-1:0]    acc_sel;
  logic [AddrWidth-1:0]  acc_idx;
  logic [Width-1:0]      acc_wdat;
  logic [Width-1:0]      ram_rd;
  logic                  ram_we;
  logic                  unused_addr;

  assign in_idx      = addr[AddrWidth+ByteOffW-1:ByteOffW];
  assign unused_addr = ^{addr[Width-1:AddrWidth+ByteOffW], addr[ByteOffW-1:0]};

  // With Latency=1 the access happens on the acceptance edge, before the
  // request registers hold anything, so the live inputs feed the array.
  assign acc_we   = (state_q == Idle) ? we     : we_q;
  assign acc_sel  = (state_q == Idle) ? sel    : sel_q;
  assign acc_idx  = (state_q == Idle) ? in_idx : idx_q;
  assign acc_wdat = (state_q == Idle) ? wr_dat : wdat_q;

  // Reset on the access edge must also suppress the write.
  assign ram_we = access & acc_we & reset;

  byte_enable_ram #(
    .Width    (Width),
    .AddrWidth(AddrWidth)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .sel   (acc_sel),
    .idx   (acc_idx),
    .wr_dat(acc_wdat),
    .rd_dat(ram_rd)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    wdat_d   = wdat_q;
    rd_dat_d = rd_dat_q;
    access   = 1'b0;

    unique case (state_q)
      Idle: begin
        if (en) begin
          we_d   = we;
          sel_d  = sel;
          idx_d  = in_idx;
          wdat_d = wr_dat;
          if (Latency == 1) begin
            access  = 1'b1;
            cnt_d   = '0;
            state_d = Ack;
          end else begin
            cnt_d   = CntWidth'(Latency - 1);
            state_d = Wait;
          end
        end
      end
      Wait: begin
        if (!en) begin
          state_d = Idle;
          cnt_d   = '0;
        end else if (cnt_q == CntWidth'(1)) begin
          access  = 1'b1;
          cnt_d   = '0;
          state_d = Ack;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      Ack: begin
        state_d = Idle;
      end
      default: begin
        state_d = Idle;
        cnt_d   = '0;
      end
    endcase

    if (access && !acc_we) rd_dat_d = ram_rd;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= Idle;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      idx_q    <= '0;
      wdat_q   <= '0;
      rd_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      wdat_q   <= wdat_d;
      rd_dat_q <= rd_dat_d;
    end
  end

  assign rd_dat = rd_dat_q;
  assign ack    = (state_q == Ack);
  assign busy   = (state_q != Idle);

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder at Latency=2 and Latency=1.
module tb_memory_responder;

  logic        clock = 1'b0;
  logic        reset;

  logic        en0, we0, ack0, busy0;
  logic [3:0]  sel0;
  logic [31:0] addr0, wdat0, rd0;

  logic        en1, we1, ack1, busy1;
  logic [3:0]  sel1;
  logic [31:0] addr1, wdat1, rd1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  memory_responder #(.Width(32), .AddrWidth(10), .Latency(2)) u_dut (
    .clock(clock), .reset(reset), .en(en0), .we(we0), .sel(sel0),
    .addr(addr0), .wr_dat(wdat0), .rd_dat(rd0), .ack(ack0), .busy(busy0)
  );

  memory_responder #(.Width(32), .AddrWidth(10), .Latency(1)) u_dut1 (
    .clock(clock), .reset(reset), .en(en1), .we(we1), .sel(sel1),
    .addr(addr1), .wr_dat(wdat1), .rd_dat(rd1), .ack(ack1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, hold en until ack, then drop it during the ack cycle.
  task automatic xact(input bit d1, input logic w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int lat, input string tag, output logic [31:0] rd);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    if (d1) begin en1 = 1'b1; we1 = w; sel1 = s; addr1 = a; wdat1 = wd; end
    else    begin en0 = 1'b1; we0 = w; sel0 = s; addr0 = a; wdat0 = wd; end
    while (!got && n < 20) begin
      @(negedge clock);
      n++;
      if (d1 ? ack1 : ack0) got = 1'b1;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_busy_in_ack"}, 32'(d1 ? busy1 : busy0), 32'd1);
    rd = d1 ? rd1 : rd0;
    if (d1) begin en1 = 1'b0; we1 = 1'b0; addr1 = 32'hFFFF_FFFC; end
    else    begin en0 = 1'b0; we0 = 1'b0; addr0 = 32'hFFFF_FFFC; end
    @(negedge clock);
    chk({tag, "_ack_one_cycle"}, 32'(d1 ? ack1 : ack0), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] exp_rd [3];
    int          ack_t [3];
    int          n_ack;
    int          cyc;

    reset = 1'b0;
    en0 = 1'b0; we0 = 1'b0; sel0 = 4'h0; addr0 = '0; wdat0 = '0;
    en1 = 1'b0; we1 = 1'b0; sel1 = 4'h0; addr1 = '0; wdat1 = '0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_ack", 32'(ack0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_rd", rd0, 32'd0);

    // Full write then read back.
    xact(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 2, "wr10", rd);
    xact(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 2, "rd10", rd);
    chk("rd10_data", rd, 32'hDEAD_BEEF);

    // Partial byte-lane write.
    xact(1'b0, 1'b1, 4'b0101, 32'h10, 32'h1122_3344, 2, "pwr10", rd);
    xact(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 2, "prd10", rd);
    chk("prd10_data", rd, 32'hDE22_BE44);

    // Aborted write leaves memory unchanged.
    en0 = 1'b1; we0 = 1'b1; sel0 = 4'hF; addr0 = 32'h10; wdat0 = 32'hFFFF_FFFF;
    @(negedge clock);
    chk("abw_busy", 32'(busy0), 32'd1);
    en0 = 1'b0;
    @(negedge clock);
    chk("abw_ack", 32'(ack0), 32'd0);
    chk("abw_idle", 32'(busy0), 32'd0);
    xact(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 2, "abw_rd", rd);
    chk("abw_mem", rd, 32'hDE22_BE44);

    // Preload words 0x0, 0x4, 0x8.
    xact(1'b0, 1'b1, 4'hF, 32'h0, 32'd1, 2, "pre0", rd);
    xact(1'b0, 1'b1, 4'hF, 32'h4, 32'd2, 2, "pre4", rd);
    xact(1'b0, 1'b1, 4'hF, 32'h8, 32'd3, 2, "pre8", rd);

    // Aborted read leaves rd_dat unchanged.
    en0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
    @(negedge clock);
    en0 = 1'b0;
    n_ack = 0;
    repeat (3) begin
      @(negedge clock);
      if (ack0) n_ack++;
    end
    chk("abr_no_ack", 32'(n_ack), 32'd0);
    chk("abr_rd_held", rd0, 32'hDE22_BE44);

    // Back-to-back reads with en held high throughout.
    exp_rd[0] = 32'd1; exp_rd[1] = 32'd2; exp_rd[2] = 32'd3;
    ack_t[0] = 0; ack_t[1] = 0; ack_t[2] = 0;
    n_ack = 0;
    en0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
    for (cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clock);
      if (ack0) begin
        if (n_ack < 3) begin
          ack_t[n_ack] = cyc;
          chk($sformatf("b2b_rd%0d", n_ack), rd0, exp_rd[n_ack]);
        end
        n_ack++;
        addr0 = 32'(n_ack * 4);
        if (n_ack >= 3) en0 = 1'b0;
      end
    end
    chk("b2b_ack_count", 32'(n_ack), 32'd3);
    chk("b2b_gap01", 32'(ack_t[1] - ack_t[0]), 32'd3);
    chk("b2b_gap12", 32'(ack_t[2] - ack_t[1]), 32'd3);

    // Reset while a write to 0x20 is waiting.
    xact(1'b0, 1'b1, 4'hF, 32'h20, 32'hCAFE_F00D, 2, "pre20", rd);
    en0 = 1'b1; we0 = 1'b1; sel0 = 4'hF; addr0 = 32'h20; wdat0 = 32'h1234_5678;
    @(negedge clock);
    chk("mid_busy", 32'(busy0), 32'd1);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_ack", 32'(ack0), 32'd0);
    reset = 1'b1;
    en0 = 1'b0; we0 = 1'b0;
    @(negedge clock);
    chk("mid_post_ack", 32'(ack0), 32'd0);
    chk("mid_post_busy", 32'(busy0), 32'd0);
    chk("mid_post_rd", rd0, 32'd0);
    xact(1'b0, 1'b0, 4'h0, 32'h20, 32'h0, 2, "mid_rd20", rd);
    chk("mid_mem20", rd, 32'hCAFE_F00D);

    // Latency=1 instance: address wrap and immediate ack.
    xact(1'b1, 1'b1, 4'hF, 32'h1000, 32'h55, 1, "l1_wr", rd);
    xact(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1, "l1_rd", rd);
    chk("l1_wrap_data", rd, 32'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
